ccrf_job_issuer: RTL

- Host-side initiator for the CCRF accelerator's job interface.
- Packs job/config commands into 576-bit incoming-job-request AXI-Stream beats and tracks in-flight job IDs.
- Consumes the 64-bit response-message stream and reports per-job completion with status and measured latency.
- Sits between the host command logic and the CCRF wrapper; used in system sim as the driver/monitor.

---
 rtl/ccrf_job_pkg.sv | 49 ++++
 rtl/ccrf_job_slot_table.sv | 118 +++++++++++
 rtl/ccrf_job_issuer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ccrf_job_pkg.sv
// Shared definitions for the CCRF job issuer: request/response beat layout,
// field offsets, status codes, FSM state type and the request packer.
package ccrf_job_pkg;

    localparam int REQ_W      = 576;
    localparam int RESP_W     = 64;
    localparam int ID_W       = 8;
    localparam int CNT_W      = 5;
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_W     = 384;
    localparam int WIDTH_LSB  = 448;
    localparam int HEIGHT_LSB = 464;
    localparam int COUNT_LSB  = 480;
    localparam int JOBID_LSB  = 512;

    localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } issuer_state_t;

    // Build one request beat; unused bits stay at 1, config messages carry
    // only the scratchpad window and a zero job ID.
    function automatic logic [REQ_W-1:0] pack_request(
        input logic              is_config,
        input logic [ID_W-1:0]   job_id,
        input logic [ADDR_W-1:0] addr,
        input logic [15:0]       width,
        input logic [15:0]       height,
        input logic [7:0]        count
    );
        logic [REQ_W-1:0] r;
        r = '1;
        if (is_config) begin
            r[127:64]            = addr[127:64];
            r[191:128]           = addr[191:128];
            r[JOBID_LSB +: ID_W] = '0;
        end else begin
            r[ADDR_LSB +: ADDR_W]  = addr;
            r[WIDTH_LSB +: 16]     = width;
            r[HEIGHT_LSB +: 16]    = height;
            r[COUNT_LSB +: 8]      = count;
            r[JOBID_LSB +: ID_W]   = job_id;
        end
        return r;
    endfunction

endpackage

// File: rtl/ccrf_job_slot_table.sv
// In-flight job tracking: lowest-free-slot allocation, lookup by job ID,
// free on response, saturating per-slot latency counters, occupancy count.
// With CCRF_JOB_TIMEOUT_EN defined it also flags the lowest slot whose
// elapsed time has reached TIMEOUT_CYCLES.
module ccrf_job_slot_table
    import ccrf_job_pkg::*;
#(
    parameter int N     = 4,
    parameter int LAT_W = 32
`ifdef CCRF_JOB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [ID_W-1:0]  alloc_id,
    input  logic             free_en,
    input  logic [ID_W-1:0]  lookup_id,
    output logic             hit,
    output logic [LAT_W-1:0] hit_lat,
    input  logic [ID_W-1:0]  query_id,
    output logic             query_busy,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             to_valid,
    output logic [ID_W-1:0]  to_id,
    input  logic             to_ack
);

    localparam int IDX_W = $clog2(N);
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [N-1:0]     slot_valid;
    logic [ID_W-1:0]  slot_id  [N];
    logic [LAT_W-1:0] slot_cnt [N];

    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] to_idx;

    // Cycles since the request handshake: the counter reads 0 in the first
    // cycle after allocation, so elapsed time is one more (saturating).
    function automatic logic [LAT_W-1:0] elapsed(input logic [LAT_W-1:0] c);
        return (c == LAT_MAX) ? c : c + LAT_W'(1);
    endfunction

    // Priority searches (downward loop so the lowest index wins) and popcount.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        query_busy = 1'b0;
        alloc_idx  = '0;
        count      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (slot_valid[i] && slot_id[i] == lookup_id) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (slot_valid[i] && slot_id[i] == query_id) begin
                query_busy = 1'b1;
            end
            if (!slot_valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
            count = count + CNT_W'(slot_valid[i]);
        end
        full    = &slot_valid;
        hit_lat = elapsed(slot_cnt[hit_idx]);
    end

    // Timeout candidate: lowest occupied slot whose elapsed time has expired.
    always_comb begin
        to_valid = 1'b0;
        to_idx   = '0;
`ifdef CCRF_JOB_TIMEOUT_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (slot_valid[i] && elapsed(slot_cnt[i]) >= LAT_W'(TIMEOUT_CYCLES)) begin
                to_valid = 1'b1;
                to_idx   = IDX_W'(i);
            end
        end
`endif
        to_id = slot_id[to_idx];
    end

    // Slot state: allocation targets a slot free at cycle start, so it never
    // collides with the slot being freed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < N; i++) begin
                slot_id[i]  <= '0;
                slot_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (alloc_en && IDX_W'(i) == alloc_idx) begin
                    slot_valid[i] <= 1'b1;
                    slot_id[i]    <= alloc_id;
                    slot_cnt[i]   <= '0;
                end else begin
                    if (slot_valid[i] && slot_cnt[i] != LAT_MAX) begin
                        slot_cnt[i] <= slot_cnt[i] + LAT_W'(1);
                    end
                    if (free_en && IDX_W'(i) == hit_idx) begin
                        slot_valid[i] <= 1'b0;
                    end
                    if (to_ack && IDX_W'(i) == to_idx) begin
                        slot_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ccrf_job_issuer.sv
// Host-side initiator for the CCRF job interface. Packs commands into
// 576-bit request beats, tracks in-flight job IDs, and turns response beats
// into completion records with status and latency.
// Optional feature macro: CCRF_JOB_TIMEOUT_EN (retire jobs after
// TIMEOUT_CYCLES with status 8'hFF).
//
// Handshakes: every stream (cmd, req, resp, done) transfers on a cycle where
// valid && ready at the rising clock edge; a producer holds valid and its
// payload stable until that transfer happens.
module ccrf_job_issuer
    import ccrf_job_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LAT_W           = 32,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_config,
    input  logic [7:0]         cmd_job_id,
    input  logic [383:0]       cmd_addr,
    input  logic [15:0]        cmd_width,
    input  logic [15:0]        cmd_height,
    input  logic [7:0]         cmd_count,
    output logic               req_tvalid,
    input  logic               req_tready,
    output logic [REQ_W-1:0]   req_tdata,
    input  logic               resp_tvalid,
    output logic               resp_tready,
    input  logic [RESP_W-1:0]  resp_tdata,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [7:0]         done_job_id,
    output logic [7:0]         done_status,
    output logic [LAT_W-1:0]   done_latency,
    output logic [4:0]         outstanding,
    output logic               err_unexpected
);

    issuer_state_t    state, state_next;
    logic             pend_is_job;
    logic             full, id_busy, hit, to_valid, to_ack;
    logic [LAT_W-1:0] hit_lat;
    logic [ID_W-1:0]  to_id;
    logic             cmd_fire, req_fire, resp_fire, free_en;
    logic             resp_unused;

    assign resp_unused = ^resp_tdata[RESP_W-1:16];

    // FSM next state and handshake outputs; ready lines stay low in reset.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        req_tvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !areset && !full && !(!cmd_is_config && id_busy);
                if (cmd_valid && cmd_ready) state_next = ST_SEND;
            end
            ST_SEND: begin
                req_tvalid = 1'b1;
                if (req_tready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign req_fire    = req_tvalid && req_tready;
    assign resp_tready = !areset && !(done_valid && !done_ready);
    assign resp_fire   = resp_tvalid && resp_tready;
    assign free_en     = resp_fire && hit;
    // A timeout retires only into a free done register and never alongside a
    // response retirement; to_valid is constant 0 without the feature.
    assign to_ack      = to_valid && (!done_valid || done_ready) && !free_en;

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Request beat capture; payload is frozen while the beat is pending.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            req_tdata   <= '1;
            pend_is_job <= 1'b0;
        end else if (cmd_fire) begin
            req_tdata   <= pack_request(cmd_is_config, cmd_job_id, cmd_addr,
                                        cmd_width, cmd_height, cmd_count);
            pend_is_job <= !cmd_is_config;
        end
    end

    ccrf_job_slot_table #(
        .N     (MAX_OUTSTANDING),
        .LAT_W (LAT_W)
`ifdef CCRF_JOB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_slots (
        .clk        (aclk),
        .rst        (areset),
        .alloc_en   (req_fire && pend_is_job),
        .alloc_id   (req_tdata[JOBID_LSB +: ID_W]),
        .free_en    (free_en),
        .lookup_id  (resp_tdata[7:0]),
        .hit        (hit),
        .hit_lat    (hit_lat),
        .query_id   (cmd_job_id),
        .query_busy (id_busy),
        .full       (full),
        .count      (outstanding),
        .to_valid   (to_valid),
        .to_id      (to_id),
        .to_ack     (to_ack)
    );

    // Completion record: response retirement wins, then timeout, then drain.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            done_valid   <= 1'b0;
            done_job_id  <= '0;
            done_status  <= '0;
            done_latency <= '0;
        end else if (free_en) begin
            done_valid   <= 1'b1;
            done_job_id  <= resp_tdata[7:0];
            done_status  <= resp_tdata[15:8];
            done_latency <= hit_lat;
        end else if (to_ack) begin
            done_valid   <= 1'b1;
            done_job_id  <= to_id;
            done_status  <= STATUS_TIMEOUT;
            done_latency <= LAT_W'(TIMEOUT_CYCLES);
        end else if (done_valid && done_ready) begin
            done_valid   <= 1'b0;
        end
    end

    // Sticky flag for responses whose ID is not in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                err_unexpected <= 1'b0;
        else if (resp_fire && !hit) err_unexpected <= 1'b1;
    end

endmodule
